hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage MIPS core; successor to the current hazard unit. It keeps the D/E forwarding and load-use/branch interlocks and adds a register-address-width parameter and a multi-cycle divider busy tracker. It also adds instruction/data memory-stall freezing, an exception flush/redirect state machine that drains an in-flight instruction fetch, and a saturating stall-cycle counter. It sits beside the datapath and drives every stage's stall and flush enables.

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/hazard_ctrl_if.sv | 43 ++++
 rtl/hazard_fwd.sv | 30 +++
 rtl/hazard_ctrl.sv | 144 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // M result is newer than W, so an M hit wins.
    function automatic logic [1:0] fwdSel(input logic hitM, input logic hitW);
        if (hitM) return FWD_M;
        if (hitW) return FWD_W;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Datapath <-> hazard controller signal bundle; master is the datapath side.
interface hazard_ctrl_if #(
    parameter int unsigned RW    = 5,
    parameter int unsigned CNT_W = 16
);
    logic [RW-1:0]    rsD, rtD;
    logic             branchD, jrD;
    logic [RW-1:0]    rsE, rtE, writeregE;
    logic             regwriteE, memtoregE;
    logic             div_startE, div_doneE;
    logic [RW-1:0]    writeregM;
    logic             regwriteM, memtoregM;
    logic             excM;
    logic [RW-1:0]    writeregW;
    logic             regwriteW;
    logic             i_stall, d_stall;
    logic             ifetch_busy;
    logic             clr_cnt;

    logic             forwardaD, forwardbD;
    logic [1:0]       forwardaE, forwardbE;
    logic             stallF, stallD, stallE, stallM;
    logic             flushD, flushE, flushM, flushW;
    logic             pc_redirect;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output rsD, rtD, branchD, jrD, rsE, rtE, writeregE, regwriteE, memtoregE,
               div_startE, div_doneE, writeregM, regwriteM, memtoregM, excM,
               writeregW, regwriteW, i_stall, d_stall, ifetch_busy, clr_cnt,
        input  forwardaD, forwardbD, forwardaE, forwardbE, stallF, stallD, stallE, stallM,
               flushD, flushE, flushM, flushW, pc_redirect, stall_cnt
    );

    modport slave (
        input  rsD, rtD, branchD, jrD, rsE, rtE, writeregE, regwriteE, memtoregE,
               div_startE, div_doneE, writeregM, regwriteM, memtoregM, excM,
               writeregW, regwriteW, i_stall, d_stall, ifetch_busy, clr_cnt,
        output forwardaD, forwardbD, forwardaE, forwardbE, stallF, stallD, stallE, stallM,
               flushD, flushE, flushM, flushW, pc_redirect, stall_cnt
    );

endinterface

// File: rtl/hazard_fwd.sv
// Operand forwarding selects for the D-stage comparators and the E-stage ALU.
module hazard_fwd
    import hazard_pkg::*;
#(
    parameter int unsigned RW = 5
) (
    input  logic [RW-1:0] rsD,
    input  logic [RW-1:0] rtD,
    input  logic [RW-1:0] rsE,
    input  logic [RW-1:0] rtE,
    input  logic [RW-1:0] writeregM,
    input  logic          regwriteM,
    input  logic [RW-1:0] writeregW,
    input  logic          regwriteW,
    output logic          forwardaD,
    output logic          forwardbD,
    output logic [1:0]    forwardaE,
    output logic [1:0]    forwardbE
);

    // Register 0 is hardwired zero, so a write to it must never be forwarded.
    assign forwardaD = (rsD != '0) && (rsD == writeregM) && regwriteM;
    assign forwardbD = (rtD != '0) && (rtD == writeregM) && regwriteM;

    assign forwardaE = fwdSel((rsE != '0) && regwriteM && (writeregM == rsE),
                              (rsE != '0) && regwriteW && (writeregW == rsE));
    assign forwardbE = fwdSel((rtE != '0) && regwriteM && (writeregM == rtE),
                              (rtE != '0) && regwriteW && (writeregW == rtE));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, interlocks, memory/divider stalls,
// exception flush with fetch drain, and a saturating stall-cycle counter.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned RW    = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic         clk,
    input  logic         resetn,
    hazard_ctrl_if.slave bus
);

    state_t           stateQ, stateD;
    logic             divBusyQ, divBusyD;
    logic [CNT_W-1:0] stallCntQ;

    logic lwstall, brstall, divstall, memstall;
    logic stallF, stallD, stallE, stallM;
    logic flushD, flushE, flushM, flushW;
    logic pcRedirect;

    hazard_fwd #(
        .RW(RW)
    ) u_fwd (
        .rsD       (bus.rsD),
        .rtD       (bus.rtD),
        .rsE       (bus.rsE),
        .rtE       (bus.rtE),
        .writeregM (bus.writeregM),
        .regwriteM (bus.regwriteM),
        .writeregW (bus.writeregW),
        .regwriteW (bus.regwriteW),
        .forwardaD (bus.forwardaD),
        .forwardbD (bus.forwardbD),
        .forwardaE (bus.forwardaE),
        .forwardbE (bus.forwardbE)
    );

    assign lwstall  = bus.memtoregE && ((bus.rtE == bus.rsD) || (bus.rtE == bus.rtD));
    assign brstall  = (bus.branchD || bus.jrD) &&
                      ((bus.regwriteE && ((bus.writeregE == bus.rsD) ||
                                          (bus.writeregE == bus.rtD))) ||
                       (bus.memtoregM && ((bus.writeregM == bus.rsD) ||
                                          (bus.writeregM == bus.rtD))));
    assign divstall = (bus.div_startE || divBusyQ) && !bus.div_doneE;
    assign memstall = bus.i_stall || bus.d_stall;

    // A start coinciding with done is a zero-latency result: never go busy.
    always_comb begin
        divBusyD = divBusyQ;
        if (bus.div_doneE) begin
            divBusyD = 1'b0;
        end else if (bus.div_startE && !divBusyQ) begin
            divBusyD = 1'b1;
        end
    end

    always_comb begin
        stateD     = stateQ;
        stallF     = 1'b0;
        stallD     = 1'b0;
        stallE     = 1'b0;
        stallM     = 1'b0;
        flushD     = 1'b0;
        flushE     = 1'b0;
        flushM     = 1'b0;
        flushW     = 1'b0;
        pcRedirect = 1'b0;
        unique case (stateQ)
            ST_RUN: begin
                if (bus.excM) begin
                    flushD = 1'b1;
                    flushE = 1'b1;
                    flushM = 1'b1;
                    flushW = 1'b1;
                    if (bus.ifetch_busy) begin
                        stateD = ST_DRAIN;
                    end else begin
                        pcRedirect = 1'b1;
                    end
                end else if (memstall) begin
                    // Freeze everything; only the retiring W slot is bubbled.
                    stallF = 1'b1;
                    stallD = 1'b1;
                    stallE = 1'b1;
                    stallM = 1'b1;
                    flushW = 1'b1;
                end else if (divstall) begin
                    stallF = 1'b1;
                    stallD = 1'b1;
                    stallE = 1'b1;
                    flushM = 1'b1;
                end else if (lwstall || brstall) begin
                    stallF = 1'b1;
                    stallD = 1'b1;
                    flushE = 1'b1;
                end
            end
            ST_DRAIN: begin
                // Wait out the outstanding fetch; its instruction is discarded.
                stallF = 1'b1;
                flushD = 1'b1;
                if (!bus.ifetch_busy) begin
                    pcRedirect = 1'b1;
                    stateD     = ST_RUN;
                end
            end
            default: stateD = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stateQ   <= ST_RUN;
            divBusyQ <= 1'b0;
        end else begin
            stateQ   <= stateD;
            divBusyQ <= divBusyD;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stallCntQ <= '0;
        end else if (bus.clr_cnt) begin
            stallCntQ <= '0;
        end else if (stallF && (stallCntQ != '1)) begin
            stallCntQ <= stallCntQ + CNT_W'(1);
        end
    end

    assign bus.stallF      = stallF;
    assign bus.stallD      = stallD;
    assign bus.stallE      = stallE;
    assign bus.stallM      = stallM;
    assign bus.flushD      = flushD;
    assign bus.flushE      = flushE;
    assign bus.flushM      = flushM;
    assign bus.flushW      = flushW;
    assign bus.pc_redirect = pcRedirect;
    assign bus.stall_cnt   = stallCntQ;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: expected outputs are queued as stimulus is
// applied and compared at the falling edge, plus directed checks from the test plan.
module tb_hazard_ctrl;

    localparam int unsigned RW    = 5;
    localparam int unsigned CNT_W = 4;

    typedef struct packed {
        logic       fad, fbd;
        logic [1:0] fae, fbe;
        logic       sF, sD, sE, sM;
        logic       fD, fE, fM, fW;
        logic       pcr;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk;
    logic resetn;
    int   nVec;
    int   nErr;

    exp_t expQ[$];
    exp_t lastExp;

    // Reference state kept by the bench.
    logic             mDrain;
    logic             mBusy;
    logic [CNT_W-1:0] mCnt;

    hazard_ctrl_if #(.RW(RW), .CNT_W(CNT_W)) bus ();

    hazard_ctrl #(
        .RW    (RW),
        .CNT_W (CNT_W)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        nVec++;
        if (got !== want) begin
            nErr++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic zeroInputs();
        bus.rsD = '0; bus.rtD = '0; bus.branchD = 0; bus.jrD = 0;
        bus.rsE = '0; bus.rtE = '0; bus.writeregE = '0;
        bus.regwriteE = 0; bus.memtoregE = 0;
        bus.div_startE = 0; bus.div_doneE = 0;
        bus.writeregM = '0; bus.regwriteM = 0; bus.memtoregM = 0; bus.excM = 0;
        bus.writeregW = '0; bus.regwriteW = 0;
        bus.i_stall = 0; bus.d_stall = 0; bus.ifetch_busy = 0; bus.clr_cnt = 0;
    endtask

    function automatic logic [1:0] refFwdE(input logic [RW-1:0] src);
        logic [1:0] r;
        r = 2'b00;
        if (src != 0) begin
            if (bus.regwriteW && bus.writeregW == src) r = 2'b01;
            if (bus.regwriteM && bus.writeregM == src) r = 2'b10;
        end
        return r;
    endfunction

    function automatic exp_t model();
        exp_t e;
        logic lw, br, dv, ms;
        e = '0;
        e.fad = (bus.rsD != 0) && (bus.rsD == bus.writeregM) && bus.regwriteM;
        e.fbd = (bus.rtD != 0) && (bus.rtD == bus.writeregM) && bus.regwriteM;
        e.fae = refFwdE(bus.rsE);
        e.fbe = refFwdE(bus.rtE);
        lw = bus.memtoregE && (bus.rtE == bus.rsD || bus.rtE == bus.rtD);
        br = (bus.branchD || bus.jrD) &&
             ((bus.regwriteE && (bus.writeregE == bus.rsD || bus.writeregE == bus.rtD)) ||
              (bus.memtoregM && (bus.writeregM == bus.rsD || bus.writeregM == bus.rtD)));
        dv = (bus.div_startE || mBusy) && !bus.div_doneE;
        ms = bus.i_stall || bus.d_stall;
        if (mDrain) begin
            e.sF = 1; e.fD = 1; e.pcr = !bus.ifetch_busy;
        end else if (bus.excM) begin
            {e.fD, e.fE, e.fM, e.fW} = 4'hF;
            e.pcr = !bus.ifetch_busy;
        end else if (ms) begin
            {e.sF, e.sD, e.sE, e.sM, e.fW} = 5'h1F;
        end else if (dv) begin
            {e.sF, e.sD, e.sE, e.fM} = 4'hF;
        end else if (lw || br) begin
            {e.sF, e.sD, e.fE} = 3'h7;
        end
        e.cnt = mCnt;
        return e;
    endfunction

    function automatic logic [14:0] packExp(input exp_t e);
        return {e.fad, e.fbd, e.fae, e.fbe, e.sF, e.sD, e.sE, e.sM,
                e.fD, e.fE, e.fM, e.fW, e.pcr};
    endfunction

    function automatic logic [14:0] dutOuts();
        return {bus.forwardaD, bus.forwardbD, bus.forwardaE, bus.forwardbE,
                bus.stallF, bus.stallD, bus.stallE, bus.stallM,
                bus.flushD, bus.flushE, bus.flushM, bus.flushW, bus.pc_redirect};
    endfunction

    // Called just after a rising edge with inputs already applied.
    task automatic driveSample();
        if (!resetn) begin
            mDrain = 0; mBusy = 0; mCnt = '0;
        end
        expQ.push_back(model());
        @(negedge clk);
        if (expQ.size() == 0) begin
            nVec++; nErr++;
            $display("FAIL scoreboard_empty got=0 want=1");
        end else begin
            lastExp = expQ.pop_front();
            check("outs", 32'(dutOuts()), 32'(packExp(lastExp)));
            check("cnt", 32'(bus.stall_cnt), 32'(lastExp.cnt));
        end
    endtask

    task automatic advance();
        if (!resetn) begin
            mDrain = 0; mBusy = 0; mCnt = '0;
        end else begin
            if (bus.clr_cnt) mCnt = '0;
            else if (lastExp.sF && mCnt != '1) mCnt = mCnt + 1'b1;
            if (bus.div_doneE) mBusy = 0;
            else if (bus.div_startE) mBusy = 1;
            if (mDrain) mDrain = bus.ifetch_busy;
            else mDrain = bus.excM && bus.ifetch_busy;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        driveSample();
        advance();
    endtask

    initial begin
        nVec = 0; nErr = 0;
        mDrain = 0; mBusy = 0; mCnt = '0;
        resetn = 0;
        zeroInputs();
        @(posedge clk); #1;

        // Reset state with all inputs low.
        driveSample();
        check("rst_outs", 32'(dutOuts()), 0);
        check("rst_cnt", 32'(bus.stall_cnt), 0);
        advance();
        resetn = 1;
        cycle();

        // Forwarding: M over W, source 0 never forwards.
        bus.rsE = 5; bus.rtE = 5; bus.regwriteM = 1; bus.writeregM = 5;
        bus.regwriteW = 1; bus.writeregW = 5;
        driveSample();
        check("fwdaE_M", 32'(bus.forwardaE), 2);
        check("fwdbE_M", 32'(bus.forwardbE), 2);
        advance();
        bus.rsE = 0;
        driveSample();
        check("fwdaE_r0", 32'(bus.forwardaE), 0);
        check("fwdbE_M2", 32'(bus.forwardbE), 2);
        advance();
        bus.rsE = 5; bus.regwriteM = 0; bus.rsD = 5;
        driveSample();
        check("fwdaE_W", 32'(bus.forwardaE), 1);
        check("fwdaD_off", 32'(bus.forwardaD), 0);
        advance();

        // Load-use, then memory stall masks the interlock bubble.
        zeroInputs();
        bus.memtoregE = 1; bus.rtE = 8; bus.rsD = 8;
        driveSample();
        check("lw_stallF", 32'(bus.stallF), 1);
        check("lw_stallD", 32'(bus.stallD), 1);
        check("lw_flushE", 32'(bus.flushE), 1);
        advance();
        bus.d_stall = 1;
        driveSample();
        check("mem_flushE", 32'(bus.flushE), 0);
        check("mem_stallM", 32'(bus.stallM), 1);
        check("mem_flushW", 32'(bus.flushW), 1);
        advance();

        // Divider: 10 stalled cycles then a done pulse.
        zeroInputs();
        bus.clr_cnt = 1;
        cycle();
        bus.clr_cnt = 0;
        bus.div_startE = 1;
        for (int i = 0; i < 10; i++) begin
            driveSample();
            check("div_stallE", 32'(bus.stallE), 1);
            advance();
        end
        bus.div_doneE = 1;
        driveSample();
        check("div_done_stallE", 32'(bus.stallE), 0);
        advance();
        zeroInputs();
        driveSample();
        check("div_cnt", 32'(bus.stall_cnt), 10);
        check("div_idle", 32'(bus.stallE), 0);
        advance();
        bus.div_startE = 1; bus.div_doneE = 1;
        driveSample();
        check("div_same_stallE", 32'(bus.stallE), 0);
        advance();
        zeroInputs();
        driveSample();
        check("div_same_busy", 32'(bus.stallF), 0);
        advance();

        // Exception with a fetch outstanding: drain, one redirect.
        bus.excM = 1; bus.ifetch_busy = 1;
        driveSample();
        check("exc_flush", 32'({bus.flushD, bus.flushE, bus.flushM, bus.flushW}), 4'hF);
        check("exc_no_pcr", 32'(bus.pc_redirect), 0);
        advance();
        bus.excM = 0;
        driveSample();
        check("drain_stallF", 32'(bus.stallF), 1);
        check("drain_flushD", 32'(bus.flushD), 1);
        advance();
        bus.excM = 1;
        driveSample();
        check("drain_exc_ign", 32'({bus.flushE, bus.flushM, bus.pc_redirect}), 0);
        advance();
        bus.excM = 0; bus.ifetch_busy = 0;
        driveSample();
        check("drain_pcr", 32'(bus.pc_redirect), 1);
        advance();
        driveSample();
        check("post_pcr", 32'(bus.pc_redirect), 0);
        check("post_stallF", 32'(bus.stallF), 0);
        advance();
        bus.excM = 1; bus.d_stall = 1;
        driveSample();
        check("exc_now_pcr", 32'(bus.pc_redirect), 1);
        check("exc_wins", 32'({bus.stallF, bus.flushE}), 1);
        advance();

        // Counter saturation and clear.
        zeroInputs();
        bus.clr_cnt = 1;
        cycle();
        bus.clr_cnt = 0; bus.i_stall = 1;
        for (int i = 0; i < 20; i++) cycle();
        driveSample();
        check("cnt_sat", 32'(bus.stall_cnt), 15);
        advance();
        bus.clr_cnt = 1;
        cycle();
        zeroInputs();
        driveSample();
        check("cnt_clr", 32'(bus.stall_cnt), 0);
        advance();

        // Reset while draining.
        bus.excM = 1; bus.ifetch_busy = 1; bus.i_stall = 1;
        cycle();
        bus.excM = 0;
        cycle();
        resetn = 0; bus.ifetch_busy = 0;
        driveSample();
        check("rst_drain_pcr", 32'(bus.pc_redirect), 0);
        check("rst_drain_cnt", 32'(bus.stall_cnt), 0);
        advance();
        resetn = 1; bus.i_stall = 0;
        driveSample();
        check("rst_after_pcr", 32'(bus.pc_redirect), 0);
        check("rst_after_stallF", 32'(bus.stallF), 0);
        advance();

        // Random mix against the reference model.
        for (int i = 0; i < 400; i++) begin
            bus.rsD = RW'($urandom_range(0, 3)); bus.rtD = RW'($urandom_range(0, 3));
            bus.rsE = RW'($urandom_range(0, 3)); bus.rtE = RW'($urandom_range(0, 3));
            bus.writeregE = RW'($urandom_range(0, 3));
            bus.writeregM = RW'($urandom_range(0, 3));
            bus.writeregW = RW'($urandom_range(0, 3));
            bus.branchD = ($urandom_range(0, 3) == 0); bus.jrD = ($urandom_range(0, 7) == 0);
            bus.regwriteE = $urandom_range(0, 1); bus.memtoregE = ($urandom_range(0, 3) == 0);
            bus.regwriteM = $urandom_range(0, 1); bus.memtoregM = ($urandom_range(0, 3) == 0);
            bus.regwriteW = $urandom_range(0, 1);
            bus.div_startE = ($urandom_range(0, 3) == 0);
            bus.div_doneE = ($urandom_range(0, 5) == 0);
            bus.excM = ($urandom_range(0, 15) == 0);
            bus.ifetch_busy = $urandom_range(0, 1);
            bus.i_stall = ($urandom_range(0, 7) == 0); bus.d_stall = ($urandom_range(0, 7) == 0);
            bus.clr_cnt = ($urandom_range(0, 31) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
